// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer that time-shares one combinational ALU between two
// valid/ready requesters, returning captured result and flags per requester.
module alu_share_ctrl #(
  parameter int DATA_W = 4,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [4:0]        rsp_flags,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_less,
  input  logic              alu_equal,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic [SEL_W-1:0]  op_sel;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              grant_id;
  logic              last_grant;
  logic              grant0;
  logic              grant1;
  logic              rsp_done;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || last_grant)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_done   = (state == RESP) && (grant_id ? rsp1_ready : rsp0_ready);

  assign alu_a   = op_a;
  assign alu_b   = op_b;
  assign alu_sel = op_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_sel     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_sel     <= grant1 ? req1_sel : req0_sel;
            op_a       <= grant1 ? req1_a : req0_a;
            op_b       <= grant1 ? req1_b : req0_b;
            grant_id   <= grant1;
            last_grant <= grant1;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_flags  <= {alu_equal, alu_less, alu_carry, alu_zero, alu_overflow};
          rsp0_valid <= !grant_id;
          rsp1_valid <= grant_id;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            op_count   <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and round-robin arbiter that time-shares the single 4-bit combinational ALU between two requesters. Each requester issues an operation (select code plus two operands) over a valid/ready handshake. The controller drives the ALU from registered operands and captures the ALU result and flags into a response register. It returns them to the granted requester over a second valid/ready handshake. It sits between the ALU and its clients and is the only block that drives the ALU inputs.

## Interface
Parameters:
- DATA_W, 4, operand/result width (must match ALU)
- SEL_W, 3, ALU op-select width
- CNT_W, 8, completed-operation counter width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid / req1_valid  in  1  requester N has an op pending
- req0_ready / req1_ready  out  1  op accepted this cycle
- req0_sel / req1_sel  in  SEL_W  ALU op code
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands
- rsp0_valid / rsp1_valid  out  1  response for requester N
- rsp0_ready / rsp1_ready  in  1  requester N takes response
- rsp_result  out  DATA_W  captured ALU result (shared bus)
- rsp_flags  out  5  captured flags {equal, less, carry, zero, overflow}
- alu_a, alu_b  out  DATA_W  ALU operand drive
- alu_sel  out  SEL_W  ALU op-select drive
- alu_result  in  DATA_W  ALU result
- alu_overflow, alu_zero, alu_carry, alu_less, alu_equal  in  1  ALU flags
- busy  out  1  state != IDLE
- op_count  out  CNT_W  completed responses, wraps

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If either reqN_valid is high, grant one requester.
  - reqN_ready is high for the granted requester only, combinationally from valid.
  - On the edge: latch sel, a and b into the operand regs, latch the grant id, update last_grant, go to EXEC.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not equal to last_grant wins.
  - last_grant resets to 1, so req0 wins the first tie.
- EXEC:
  - alu_a, alu_b and alu_sel are driven from the operand regs.
  - On the edge: capture alu_result and the five flags into the response regs, go to RESP.
- RESP:
  - rspN_valid is high for the latched grant id only.
  - rsp_result and rsp_flags are stable from the response regs.
  - On the edge where rspN_ready is high: go to IDLE and increment op_count (mod 2^CNT_W).
  - rspN_ready on the non-granted port is ignored.
- Outside EXEC, alu_* continue to show the operand regs; the values are held, not zeroed.
- Both reqN_ready are low in EXEC and RESP. Requesters must hold valid and payload stable until ready; the payload is sampled only at accept.
- Flags are passed through unmodified. The controller performs no arithmetic on data.

## Timing
- Reset: asynchronous assert. All regs clear immediately:
  - state = IDLE
  - operand regs, response regs, alu_*, rsp_result, rsp_flags = 0
  - rspN_valid = 0, busy = 0, op_count = 0, last_grant = 1
- Reset mid-operation: the in-flight op is dropped and no response is issued after release. The first edge after deassert behaves as IDLE.
- Latency:
  - Accept edge at T.
  - ALU is driven during cycle T+1.
  - Response is captured at the end of T+1.
  - rspN_valid is high from cycle T+2.
- Throughput:
  - With rsp_ready already high: 3 cycles per op.
  - Back-to-back ops alternate requesters when both are valid.
- rspN_valid, once raised, stays high with constant data until the ready handshake or reset.
- No accept happens in the cycle a response completes. A new accept is possible in the following IDLE cycle.
- op_count wraps from 2^CNT_W−1 to 0 without side effects.

## Test plan
- Add with overflow:
  - Stimulus: req0 sel=000, a=7, b=1.
  - Response: rsp0_valid 2 cycles after accept, result=8, flags overflow=1, zero=0; rsp1_valid stays 0.
- Subtract to zero:
  - Stimulus: req1 sel=001, a=3, b=3.
  - Response: result=0, zero=1, overflow=0; rsp1_valid only.
- Signed less-than:
  - Stimulus: req0 sel=110, a=2, b=5.
  - Response: result=0xD, less=1, overflow=0.
- Contention and fairness:
  - Stimulus: both requesters held valid for 4 ops (req0 sel=111 a=4 b=4; req1 sel=011 a=0xC b=0xA), rsp ready tied high.
  - Response: grants go 0,1,0,1 with an accept every 3 cycles.
  - req0 responses show equal=1, result=0; req1 responses show result=8.
  - op_count=4.
- Response backpressure:
  - Stimulus: hold rsp0_ready=0 for 5 cycles after rsp0_valid rises, with req1 valid throughout.
  - Response: rsp0 data stays constant, req1_ready stays 0, and req1 is accepted in the IDLE cycle after the handshake.
- Reset mid-op:
  - Stimulus: assert rst_n=0 during EXEC, then release.
  - Response: all outputs are 0 immediately, no rsp_valid appears, and the next tie grants req0.
